// File: rtl/dff_stim_gen.sv
// rtl/dff_stim_gen.sv - reset-pulse plus LFSR toggle stimulus generator for negedge flops under test
// Optional toggle counter output TOG_CNT enabled by defining DFF_STIM_TOGGLE_COUNT_EN.
module dff_stim_gen #(
    parameter int          WIDTH      = 8,
    parameter int          RST_CYCLES = 4,
    parameter int          RUN_CYCLES = 1024,
    parameter logic [15:0] SEED       = 16'hACE1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [1:0]       ACT_SEL,
    output logic [WIDTH-1:0] D_OUT,
    output logic             RSTB_OUT,
    output logic             BUSY,
    output logic             DONE
`ifdef DFF_STIM_TOGGLE_COUNT_EN
    ,
    output logic [31:0]      TOG_CNT
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_RSTP, S_RUN, S_FIN} state_t;

    localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'hACE1 : SEED;
    localparam logic [15:0] RST_LOAD = 16'(RST_CYCLES - 1);
    localparam logic [15:0] RUN_LOAD = 16'(RUN_CYCLES - 1);

    state_t           state_q, state_d;
    logic [15:0]      cnt_q, cnt_d;
    logic [1:0]       act_q, act_d;
    logic [15:0]      lfsr_q, lfsr_d;
    logic [WIDTH-1:0] d_out_q, d_out_d;
    logic             rstb_q, rstb_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] tog_vec;
    logic             enter_rstp;

    // Per-lane toggle mask; lane index wraps mod 16 for the pairwise AND mode
    for (genvar g = 0; g < WIDTH; g++) begin : g_lane
        localparam int LO = (2 * g) % 16;
        localparam int HI = (2 * g + 1) % 16;
        assign tog_vec[g] = (act_q == 2'd0) ? 1'b0 :
                            (act_q == 2'd1) ? (lfsr_q[LO] & lfsr_q[HI]) :
                            (act_q == 2'd2) ? lfsr_q[g] : 1'b1;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        act_d   = act_q;
        case (state_q)
            S_IDLE: begin
                if (START) begin
                    state_d = S_RSTP;
                    cnt_d   = RST_LOAD;
                    act_d   = ACT_SEL;
                end
            end
            S_RSTP: begin
                if (cnt_q == 16'd0) begin
                    state_d = S_RUN;
                    cnt_d   = RUN_LOAD;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            S_RUN: begin
                if (cnt_q == 16'd0) begin
                    state_d = S_FIN;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign enter_rstp = (state_q == S_IDLE) && (state_d == S_RSTP);

    // Outputs are derived from the next state so every pin changes with the state register
    always_comb begin
        lfsr_d  = lfsr_q;
        d_out_d = d_out_q;
        rstb_d  = 1'b1;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        case (state_d)
            S_RSTP: begin
                rstb_d  = 1'b0;
                busy_d  = 1'b1;
                d_out_d = '0;
                if (enter_rstp) begin
                    lfsr_d = SEED_EFF;
                end
            end
            S_RUN: begin
                busy_d  = 1'b1;
                d_out_d = d_out_q ^ tog_vec;
                lfsr_d  = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
            end
            S_FIN:   done_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            act_q   <= '0;
            lfsr_q  <= SEED_EFF;
            d_out_q <= '0;
            rstb_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            act_q   <= act_d;
            lfsr_q  <= lfsr_d;
            d_out_q <= d_out_d;
            rstb_q  <= rstb_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign D_OUT    = d_out_q;
    assign RSTB_OUT = rstb_q;
    assign BUSY     = busy_q;
    assign DONE     = done_q;

`ifdef DFF_STIM_TOGGLE_COUNT_EN
    logic [31:0] tog_cnt_q, tog_cnt_d;
    logic [32:0] tog_sum;

    assign tog_sum = {1'b0, tog_cnt_q} + 33'($countones(d_out_d ^ d_out_q));

    always_comb begin
        tog_cnt_d = tog_cnt_q;
        if (enter_rstp) begin
            tog_cnt_d = '0;
        end else if (state_d == S_RUN) begin
            tog_cnt_d = tog_sum[32] ? 32'hFFFF_FFFF : tog_sum[31:0];
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            tog_cnt_q <= '0;
        end else begin
            tog_cnt_q <= tog_cnt_d;
        end
    end

    assign TOG_CNT = tog_cnt_q;
`endif

endmodule

// File: tb/tb_dff_stim_gen.sv
// tb/tb_dff_stim_gen.sv - directed self-checking bench for dff_stim_gen (three parameter sets)
module tb_dff_stim_gen;

    localparam int RSTC = 4;

    logic       clk = 1'b0;
    logic [2:0] rst_i   = 3'b111;
    logic [2:0] start_i = 3'b000;
    logic [1:0] sel_i [3];
    logic [7:0] d_o [3];
    logic [2:0] rb_o, busy_o, done_o;
`ifdef DFF_STIM_TOGGLE_COUNT_EN
    logic [31:0] tog_o [3];
`endif

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    dff_stim_gen u0 (
        .CLK(clk), .RST(rst_i[0]), .START(start_i[0]), .ACT_SEL(sel_i[0]),
        .D_OUT(d_o[0]), .RSTB_OUT(rb_o[0]), .BUSY(busy_o[0]),
`ifdef DFF_STIM_TOGGLE_COUNT_EN
        .TOG_CNT(tog_o[0]),
`endif
        .DONE(done_o[0])
    );

    dff_stim_gen #(.RUN_CYCLES(16), .SEED(16'h0000)) u1 (
        .CLK(clk), .RST(rst_i[1]), .START(start_i[1]), .ACT_SEL(sel_i[1]),
        .D_OUT(d_o[1]), .RSTB_OUT(rb_o[1]), .BUSY(busy_o[1]),
`ifdef DFF_STIM_TOGGLE_COUNT_EN
        .TOG_CNT(tog_o[1]),
`endif
        .DONE(done_o[1])
    );

    dff_stim_gen #(.RUN_CYCLES(100)) u2 (
        .CLK(clk), .RST(rst_i[2]), .START(start_i[2]), .ACT_SEL(sel_i[2]),
        .D_OUT(d_o[2]), .RSTB_OUT(rb_o[2]), .BUSY(busy_o[2]),
`ifdef DFF_STIM_TOGGLE_COUNT_EN
        .TOG_CNT(tog_o[2]),
`endif
        .DONE(done_o[2])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    function automatic logic [7:0] tmask(input logic [1:0] act, input logic [15:0] l);
        logic [7:0] t;
        for (int i = 0; i < 8; i++) begin
            case (act)
                2'd0:    t[i] = 1'b0;
                2'd1:    t[i] = l[(2 * i) % 16] & l[(2 * i + 1) % 16];
                2'd2:    t[i] = l[i];
                default: t[i] = 1'b1;
            endcase
        end
        return t;
    endfunction

    task automatic reset_unit(input int u);
        rst_i[u] = 1'b1;
        repeat (3) tick();
        check($sformatf("u%0d_rst_d", u), 32'(d_o[u]), 32'h0);
        check($sformatf("u%0d_rst_rstb", u), 32'(rb_o[u]), 32'h0);
        check($sformatf("u%0d_rst_busy", u), 32'(busy_o[u]), 32'h0);
        check($sformatf("u%0d_rst_done", u), 32'(done_o[u]), 32'h0);
        rst_i[u] = 1'b0;
        tick();
        check($sformatf("u%0d_rel_rstb", u), 32'(rb_o[u]), 32'h1);
        check($sformatf("u%0d_rel_busy", u), 32'(busy_o[u]), 32'h0);
    endtask

    // One full sequence; k counts edges with k=1 being the edge that samples START
    task automatic run_seq(input int u, input int runc, input logic [15:0] seed,
                           input logic [1:0] act, input bit hold);
        logic [15:0] l;
        logic [7:0]  dm, dn;
        logic        e_rb, e_busy, e_done;
        int          tog_m;
        l     = seed;
        dm    = 8'h00;
        tog_m = 0;
        start_i[u] = 1'b1;
        sel_i[u]   = act;
        for (int k = 1; k <= RSTC + runc + 2; k++) begin
            tick();
            if (k == 1 && !hold) start_i[u] = 1'b0;
            if (k <= RSTC) begin
                e_rb = 1'b0; e_busy = 1'b1; e_done = 1'b0; dm = 8'h00;
            end else if (k <= RSTC + runc) begin
                dn = dm ^ tmask(act, l);
                tog_m += $countones(dn ^ dm);
                dm = dn;
                l  = lfsr_step(l);
                e_rb = 1'b1; e_busy = 1'b1; e_done = 1'b0;
            end else begin
                e_rb = 1'b1; e_busy = 1'b0; e_done = (k == RSTC + runc + 1);
            end
            check($sformatf("u%0d_a%0d_d k%0d", u, act, k), 32'(d_o[u]), 32'(dm));
            check($sformatf("u%0d_a%0d_rstb k%0d", u, act, k), 32'(rb_o[u]), 32'(e_rb));
            check($sformatf("u%0d_a%0d_busy k%0d", u, act, k), 32'(busy_o[u]), 32'(e_busy));
            check($sformatf("u%0d_a%0d_done k%0d", u, act, k), 32'(done_o[u]), 32'(e_done));
        end
`ifdef DFF_STIM_TOGGLE_COUNT_EN
        check($sformatf("u%0d_a%0d_tog", u, act), tog_o[u], 32'(tog_m));
`endif
    endtask

    initial begin
        for (int i = 0; i < 3; i++) sel_i[i] = 2'd0;

        // Defaults, full-activity alternation, DONE on edge 1029
        reset_unit(0);
        run_seq(0, 1024, 16'hACE1, 2'd3, 1'b0);

        // START held through a whole sequence restarts one cycle after FIN
        run_seq(0, 1024, 16'hACE1, 2'd3, 1'b1);
        tick();
        check("u0_restart_busy", 32'(busy_o[0]), 32'h1);
        check("u0_restart_rstb", 32'(rb_o[0]), 32'h0);
        for (int k = 2; k <= RSTC + 10; k++) tick();
        check("u0_run10_busy", 32'(busy_o[0]), 32'h1);
        check("u0_run10_d", 32'(d_o[0]), 32'h00);

        // Reset at RUN cycle 10 aborts without DONE
        rst_i[0]   = 1'b1;
        start_i[0] = 1'b0;
        tick();
        check("u0_abort_d", 32'(d_o[0]), 32'h0);
        check("u0_abort_rstb", 32'(rb_o[0]), 32'h0);
        check("u0_abort_busy", 32'(busy_o[0]), 32'h0);
        check("u0_abort_done", 32'(done_o[0]), 32'h0);
        rst_i[0] = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            check($sformatf("u0_post_done k%0d", k), 32'(done_o[0]), 32'h0);
            check($sformatf("u0_post_rstb k%0d", k), 32'(rb_o[0]), 32'h1);
        end

        // SEED=0 falls back to ACE1; quiet mode then single-bit LFSR mode
        reset_unit(1);
        run_seq(1, 16, 16'hACE1, 2'd0, 1'b0);
        run_seq(1, 16, 16'hACE1, 2'd2, 1'b0);

        // 100-cycle full toggle gives 800 lane changes; then pairwise-AND mode
        reset_unit(2);
        run_seq(2, 100, 16'hACE1, 2'd3, 1'b0);
`ifdef DFF_STIM_TOGGLE_COUNT_EN
        check("u2_tog_800", tog_o[2], 32'd800);
`endif
        run_seq(2, 100, 16'hACE1, 2'd1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
